// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and defaults for the reset sequencer slice.
//   seq_state_t    : sequencer FSM state encoding (IDLE, HOLD, RELEASE)
//   SEQ_*_DEF      : default values for STAGES / HOLD_CYCLES / GAP_CYCLES
//   max_int()      : constant helper used to size the shared counter
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} seq_state_t;

  localparam int SEQ_STAGES_DEF = 3;
  localparam int SEQ_HOLD_DEF   = 16;
  localparam int SEQ_GAP_DEF    = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Groups the request input and the per-stage reset outputs of the sequencer.
//   req      : reset request (one-cycle pulse, or any level when synchronized)
//   rst_out  : per-stage active-high resets, bit 0 released first
//   busy     : high while a sequence is in progress
//   done     : one-cycle pulse when the last stage is released
// Modports:
//   master : the side that requests resets and observes the stage resets
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int STAGES = SEQ_STAGES_DEF
) ();

  logic              req;
  logic [STAGES-1:0] rst_out;
  logic              busy;
  logic              done;

  modport master (output req, input rst_out, input busy, input done);
  modport slave  (input req, output rst_out, output busy, output done);

endinterface

// File: rtl/req_sync.sv
// -----------------------------------------------------------------------------
// req_sync
// Brings an asynchronous or long-level request into the clk domain and turns
// its rising edge into a single-cycle pulse. Adds two cycles of latency.
//   clk      : sampling clock
//   rst      : asynchronous active-high reset, clears all flops to 0
//   async_i  : raw request, any timing, any length
//   pulse_o  : one-cycle pulse per rising edge of async_i
// -----------------------------------------------------------------------------
module req_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // meta_q may go metastable; only sync_q is used by downstream logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // A held level yields exactly one pulse, on its first synchronized cycle.
  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Turns a reset request (or the global asynchronous reset) into per-stage
// active-high resets. All stages are held for HOLD_CYCLES, then released one
// by one, bit 0 first, GAP_CYCLES apart. A new request at any edge restarts
// the whole sequence and suppresses any release or done due on that edge.
//
// Parameters:
//   STAGES       : number of reset outputs, 1..8
//   HOLD_CYCLES  : cycles all stages stay asserted before the first release
//   GAP_CYCLES   : cycles between consecutive stage releases
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset (forces HOLD, all stages asserted)
//   bus  : reset_sequencer_if slave (req in; rst_out, busy, done out)
//
// Build option RESET_SEQUENCER_SYNC_EN:
//   defined   - req goes through req_sync (2-flop sync + rising-edge detect),
//               so it may be asynchronous or a long level; +2 cycles latency.
//   undefined - req is a synchronous pulse; every high edge restarts.
// -----------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int STAGES      = SEQ_STAGES_DEF,
  parameter int HOLD_CYCLES = SEQ_HOLD_DEF,
  parameter int GAP_CYCLES  = SEQ_GAP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.slave  bus
);

  // Sized so neither terminal count can wrap the counter.
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES)) + 1;
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] STAGE_LAST = IDX_W'(STAGES - 1);

  generate
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
      $error("reset_sequencer: STAGES must be in 1..8");
    end
    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cycles
      $error("reset_sequencer: HOLD_CYCLES and GAP_CYCLES must be >= 1");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  logic req_fsm;

`ifdef RESET_SEQUENCER_SYNC_EN
  req_sync u_req_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.req),
    .pulse_o (req_fsm)
  );
`else
  assign req_fsm = bus.req;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  seq_state_t        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [STAGES-1:0] rst_out_q, rst_out_d;
  logic              done_q,    done_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // Release order is fixed (bit 0 first), so rst_out is always a run of ones
  // in the upper bits; clearing bit idx is the same as shifting left by one.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = 1'b0;

    if (req_fsm) begin
      // Restart wins over any release or done due on this edge.
      state_d   = HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '0;
        end

        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d     = '0;
            rst_out_d = rst_out_q << 1;
            if (STAGES == 1) begin
              state_d = IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d     = '0;
            rst_out_d = rst_out_q << 1;
            if (idx_q == STAGE_LAST) begin
              state_d = IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: begin
          // Unused encoding: recover by running a full sequence.
          state_d   = HOLD;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign bus.rst_out = rst_out_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

endmodule
